// File: rtl/md_pkg.sv
// Shared encodings, default latencies and FSM state type for the multiply/divide controller.
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int MD_MUL_LAT_DEF = 5;
  localparam int MD_DIV_LAT_DEF = 10;
  localparam int MD_CNT_W_DEF   = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// E/D-stage <-> multiply/divide unit bundle; md_flush exists only when MD_FLUSH_EN is defined.
// Handshake: md_start is a single-cycle pulse accepted only while busy is low; stall tells
// the hazard unit to hold a D-stage md-class instruction while busy or a start is in E.
interface muldiv_ctrl_if;
  import md_pkg::*;

  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        md_use_d;
`ifdef MD_FLUSH_EN
  logic        md_flush;
`endif
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  md_state_e   state;

  modport master (
    output md_start, md_op, src_a, src_b, md_use_d,
`ifdef MD_FLUSH_EN
    output md_flush,
`endif
    input  busy, stall, hi, lo, state
  );

  modport slave (
    input  md_start, md_op, src_a, src_b, md_use_d,
`ifdef MD_FLUSH_EN
    input  md_flush,
`endif
    output busy, stall, hi, lo, state
  );
endinterface

// File: rtl/md_calc.sv
// Combinational 32x32 multiply / divide datapath producing the {hi,lo} pair.
module md_calc
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic signed [63:0] a_ext;
  logic signed [63:0] b_ext;
  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic        [31:0] b_nz;
  logic        [31:0] quo;
  logic        [31:0] rem;

  // Divisor of zero is replaced by one so the divider never sees zero; result is discarded.
  assign b_nz  = (b == 32'd0) ? 32'd1 : b;
  assign a_ext = {{32{a[31]}}, a};
  assign b_ext = {{32{b[31]}}, b};
  assign a_s   = a;
  assign b_s   = b_nz;

  always_comb begin
    result      = '0;
    div_by_zero = 1'b0;
    quo         = '0;
    rem         = '0;
    case (op)
      MD_MULT:  result = a_ext * b_ext;
      MD_MULTU: result = {32'd0, a} * {32'd0, b};
      MD_DIV: begin
        div_by_zero = (b == 32'd0);
        // Most-negative / -1 overflows; the architected answer is q=a, r=0.
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          quo = 32'h8000_0000;
          rem = 32'd0;
        end else begin
          quo = a_s / b_s;
          rem = a_s % b_s;
        end
        result = {rem, quo};
      end
      MD_DIVU: begin
        div_by_zero = (b == 32'd0);
        result      = {a % b_nz, a / b_nz};
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer owning HI/LO, with fixed-latency busy counter and hazard stall.
// Optional MD_FLUSH_EN adds md_flush to abort an in-flight op and squash a concurrent start.
module muldiv_ctrl
  import md_pkg::*;
#(
  parameter int MUL_LAT = MD_MUL_LAT_DEF,
  parameter int DIV_LAT = MD_DIV_LAT_DEF,
  parameter int CNT_W   = MD_CNT_W_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  muldiv_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  md_state_e        state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [31:0]      pend_hi, pend_hi_d;
  logic [31:0]      pend_lo, pend_lo_d;
  logic             pend_wr, pend_wr_d;
  logic [31:0]      hi, hi_d;
  logic [31:0]      lo, lo_d;

  logic [63:0]      calc_res;
  logic             calc_dz;
  logic             flush;
  logic             is_arith;
  logic             is_div;

`ifdef MD_FLUSH_EN
  assign flush = bus.md_flush;
`else
  assign flush = 1'b0;
`endif

  assign is_arith = (bus.md_op <= MD_DIVU);
  assign is_div   = (bus.md_op == MD_DIV) || (bus.md_op == MD_DIVU);

  md_calc u_calc (
    .op          (bus.md_op),
    .a           (bus.src_a),
    .b           (bus.src_b),
    .result      (calc_res),
    .div_by_zero (calc_dz)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      pend_hi <= pend_hi_d;
      pend_lo <= pend_lo_d;
      pend_wr <= pend_wr_d;
      hi      <= hi_d;
      lo      <= lo_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    pend_hi_d = pend_hi;
    pend_lo_d = pend_lo;
    pend_wr_d = pend_wr;
    hi_d      = hi;
    lo_d      = lo;
    unique case (state)
      ST_IDLE: begin
        if (bus.md_start && !flush) begin
          if (is_arith) begin
            state_d   = ST_RUN;
            cnt_d     = is_div ? DIV_CNT : MUL_CNT;
            pend_hi_d = calc_res[63:32];
            pend_lo_d = calc_res[31:0];
            // A zero divisor still occupies the unit but leaves HI/LO untouched.
            pend_wr_d = !calc_dz;
          end else if (bus.md_op == MD_MTHI) begin
            hi_d = bus.src_a;
          end else if (bus.md_op == MD_MTLO) begin
            lo_d = bus.src_a;
          end
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          pend_wr_d = 1'b0;
        end else if (cnt == '0) begin
          state_d   = ST_IDLE;
          pend_wr_d = 1'b0;
          if (pend_wr) begin
            hi_d = pend_hi;
            lo_d = pend_lo;
          end
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy  = (state == ST_RUN);
  assign bus.stall = bus.md_use_d & ((state == ST_RUN) | bus.md_start);
  assign bus.hi    = hi;
  assign bus.lo    = lo;
  assign bus.state = state;

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Sequences the multi-cycle multiply/divide resource of the 5-stage MIPS pipeline and owns the HI/LO registers. It accepts one md-class instruction from the E stage and models fixed multiply/divide latency with a busy counter. It drives the stall request consumed by the hazard unit whenever a D-stage md-class instruction (mult/multu/div/divu/mthi/mtlo/mfhi/mflo) would collide with an in-flight operation.

Parameters:
MUL_LAT, 5, busy cycles for MULT/MULTU; must be ≥1
DIV_LAT, 10, busy cycles for DIV/DIVU; must be ≥1
CNT_W, 4, counter width; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
md_start  in  1  E-stage md instruction valid this cycle (one pulse per instruction)
md_op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6/7 are no-op
src_a  in  32  rs operand (forwarded)
src_b  in  32  rt operand (forwarded)
md_use_d  in  1  D-stage instruction is md-class
busy  out  1  operation in flight
stall  out  1  stall request to hazard unit
hi  out  32  HI register
lo  out  32  LO register

Behaviour:
- Reset (async, reset_n=0): state IDLE, cnt=0, busy=0, hi=0, lo=0, pending regs=0. Any in-flight op is aborted with no HI/LO write.
- States: IDLE, RUN. busy = (state==RUN), registered.
- IDLE with md_start and md_op in 0..3:
  - compute the 64-bit result combinationally and latch it into pend_hi/pend_lo;
  - cnt <= LAT-1;
  - go to RUN.
  - busy is high for exactly LAT cycles starting at the next edge.
- RUN: cnt decrements each edge. On the edge where cnt==0: hi<=pend_hi, lo<=pend_lo, state<=IDLE, busy<=0. New HI/LO are visible in the first cycle busy is low.
- MTHI/MTLO in IDLE: hi (resp. lo) <= src_a at the next edge. No busy, no counter activity.
- md_start while in RUN is a protocol violation: ignored, no state change. The bench asserts it never occurs.
- stall = md_use_d & (busy | md_start), combinational. stall is 0 when md_use_d=0.
- MULT: signed 32x32 giving {hi,lo}. MULTU: unsigned.
- DIV: lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign. 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. DIVU: unsigned.
- Divide by zero (src_b==0): still busy for DIV_LAT cycles; hi/lo retain their prior values.
- md_op 6/7 with md_start: ignored.

Optional Feature:
MD_FLUSH_EN:
- When defined, adds input md_flush (1 bit), sourced from exception/flush logic.
- md_flush=1 in RUN: state<=IDLE, busy<=0 and cnt<=0 at the next edge; pending result is discarded and hi/lo are unchanged.
- md_flush=1 concurrent with md_start: the start, including MTHI/MTLO, is ignored.
- When not defined: the port is absent and every started op completes.

Decomposition:
- Package md_pkg: md_op encodings (MD_MULT..MD_MTLO), default MUL_LAT/DIV_LAT constants, state enum.
- Sub-module md_calc: purely combinational. Inputs op, a, b. Outputs 64-bit {hi,lo} result and a div_by_zero flag.
- Counter, FSM and HI/LO registers stay in muldiv_ctrl.

Test Plan:
- After reset, MULT a=0xFFFFFFFF b=0x00000002: busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU same operands: hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
- DIV a=0xFFFFFFF9 (-7) b=2: after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU a=7 b=0: busy 10 cycles, hi/lo unchanged.
- Stall:
  - md_use_d=1 held through DIV: stall=1 in the start cycle and all 10 busy cycles, 0 in the first idle cycle.
  - md_use_d=0: stall=0 throughout.
- MTHI a=0x00001234 from IDLE: hi=0x00001234 next edge, busy never rises. MTLO a=0xCAFEBABE: lo updated likewise.
- Reset mid-op: reset_n=0 on DIV busy cycle 4 gives busy=0, hi=lo=0 immediately with no late write.
- Flush (MD_FLUSH_EN): md_flush on MULT busy cycle 2 gives busy=0 next edge and hi/lo keep their prior values.
